// File: rtl/g_udp_rxbuf_pkg.sv
// Shared types and constants for the UDP receive payload buffer.
package g_udp_rxbuf_pkg;

    localparam int unsigned DEPTH  = 512;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StPrime,
        StDrain,
        StFlush
    } state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/g_udp_rxbuf_if.sv
// Producer/consumer signal bundle for the UDP receive payload buffer.
interface g_udp_rxbuf_if #(
    parameter int unsigned DATA_W = g_udp_rxbuf_pkg::DATA_W
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              frame_done;
    logic [15:0]       in_bytes;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [15:0]       out_bytes;
    logic              busy;
    logic [7:0]        drop_cnt;

    modport master (
        output in_valid, in_data, frame_done, in_bytes, out_ready,
        input  out_data, out_valid, out_last, out_bytes, busy, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, frame_done, in_bytes, out_ready,
        output out_data, out_valid, out_last, out_bytes, busy, drop_cnt
    );
endinterface

// File: rtl/g_rxbuf_ram.sv
// Simple dual-port payload RAM: one write port, one registered read port with enable.
module g_rxbuf_ram #(
    parameter int unsigned ADDR_W = g_udp_rxbuf_pkg::ADDR_W,
    parameter int unsigned DATA_W = g_udp_rxbuf_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/g_udp_rxbuf.sv
// Buffers one UDP payload frame, then drains it to the consumer; frames that overflow
// or arrive while draining are discarded and counted.
module g_udp_rxbuf #(
    parameter int unsigned ADDR_W = g_udp_rxbuf_pkg::ADDR_W,
    parameter int unsigned DATA_W = g_udp_rxbuf_pkg::DATA_W
) (
    input logic          clk,
    input logic          clr,
    g_udp_rxbuf_if.slave bus
);
    import g_udp_rxbuf_pkg::*;

    localparam int unsigned      CntW    = ADDR_W + 1;
    localparam logic [CntW-1:0]  FullCnt = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CntW-1:0]  CntOne  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [CntW-1:0]   wr_ptr_q, wr_ptr_d, cnt_q, cnt_d, rd_idx_q, rd_idx_d;
    logic              ovf_q, ovf_d, pend_q, pend_d, out_valid_q, out_valid_d;
    logic [15:0]       bytes_q, bytes_d;
    logic [7:0]        drop_q, drop_d;
    logic              we, re, xfer, last, busy;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;

    assign busy = (state_q != StIdle) && (state_q != StFill);
    assign xfer = out_valid_q & bus.out_ready;
    assign last = out_valid_q && (rd_idx_q == cnt_q - CntOne);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            rd_idx_q    <= '0;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            bytes_q     <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            rd_idx_q    <= rd_idx_d;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            bytes_q     <= bytes_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        rd_idx_d    = rd_idx_q;
        ovf_d       = ovf_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        bytes_d     = bytes_q;
        drop_d      = drop_q;
        we          = 1'b0;
        re          = 1'b0;
        raddr       = '0;

        // A frame seen while the buffer is occupied is tracked so its end can be counted.
        if (busy) begin
            if (bus.in_valid) pend_d = 1'b1;
            if (bus.frame_done) begin
                pend_d = 1'b0;
                drop_d = sat_inc(drop_q);
            end
        end

        unique case (state_q)
            StIdle, StFill: begin
                if (bus.in_valid) begin
                    if (wr_ptr_q == FullCnt) begin
                        ovf_d = 1'b1;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + CntOne;
                    end
                    state_d = StFill;
                end
                if (bus.frame_done && (state_q == StFill || bus.in_valid)) begin
                    if (ovf_d) begin
                        ovf_d   = 1'b0;
                        drop_d  = sat_inc(drop_q);
                        state_d = StIdle;
                    end else begin
                        cnt_d   = wr_ptr_d;
                        bytes_d = bus.in_bytes;
                        state_d = StPrime;
                    end
                    wr_ptr_d = '0;
                end
            end
            StPrime: begin
                re          = 1'b1;
                rd_idx_d    = '0;
                out_valid_d = 1'b1;
                state_d     = StDrain;
            end
            StDrain: begin
                if (xfer) begin
                    if (last) begin
                        out_valid_d = 1'b0;
                        state_d     = pend_d ? StFlush : StIdle;
                    end else begin
                        re       = 1'b1;
                        rd_idx_d = rd_idx_q + CntOne;
                        raddr    = rd_idx_d[ADDR_W-1:0];
                    end
                end
            end
            StFlush: begin
                if (bus.frame_done) state_d = StIdle;
            end
        endcase
    end

    g_rxbuf_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (we),
        .waddr_i(wr_ptr_q[ADDR_W-1:0]),
        .wdata_i(bus.in_data),
        .re_i   (re),
        .raddr_i(raddr),
        .rdata_o(rdata)
    );

    // RAM output is masked so a reset or idle buffer presents zero data.
    assign bus.out_data  = out_valid_q ? rdata : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = last;
    assign bus.out_bytes = bytes_q;
    assign bus.busy      = busy;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_g_udp_rxbuf.sv
// Directed self-checking bench for g_udp_rxbuf.
module tb_g_udp_rxbuf;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    g_udp_rxbuf_if bus ();

    g_udp_rxbuf #(
        .ADDR_W(9),
        .DATA_W(32)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] tx_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic        got_last_q[$];
    bit          ready_pat[4];
    int          first_valid;
    int          unstable;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_seq(input int n, input logic [31:0] base);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(base + i);
    endtask

    // Streams tx_q; frame_done either rides the last word or follows it.
    task automatic send_frame(input logic [15:0] nbytes, input bit coincide);
        for (int i = 0; i < tx_q.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tx_q[i];
            if (coincide && i == tx_q.size() - 1) begin
                bus.frame_done = 1'b1;
                bus.in_bytes   = nbytes;
            end
            tick();
        end
        bus.in_valid   = 1'b0;
        bus.frame_done = 1'b0;
        if (!coincide) begin
            bus.frame_done = 1'b1;
            bus.in_bytes   = nbytes;
            tick();
            bus.frame_done = 1'b0;
        end
    endtask

    // Called one cycle after the frame_done cycle; records accepted words until out_last.
    task automatic collect(input int max_cyc);
        int          vcnt = 0;
        bit          stalled = 1'b0;
        logic [31:0] hold_d = '0;
        logic        hold_l = 1'b0;
        got_q.delete();
        got_last_q.delete();
        first_valid = -1;
        unstable    = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            if (bus.out_valid) begin
                if (first_valid < 0) first_valid = i;
                if (stalled && (bus.out_data !== hold_d || bus.out_last !== hold_l)) unstable++;
                bus.out_ready = ready_pat[vcnt % 4];
                vcnt++;
                if (bus.out_ready) begin
                    got_q.push_back(bus.out_data);
                    got_last_q.push_back(bus.out_last);
                    stalled = 1'b0;
                    if (bus.out_last) begin
                        tick();
                        bus.out_ready = 1'b1;
                        return;
                    end
                end else begin
                    stalled = 1'b1;
                    hold_d  = bus.out_data;
                    hold_l  = bus.out_last;
                end
            end
            tick();
        end
        bus.out_ready = 1'b1;
        $display("FAIL collect_timeout: got %0d words after %0d cycles, want out_last",
                 got_q.size(), max_cyc);
        n_tests++;
        n_fail++;
    endtask

    task automatic check_words(input string name);
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d words want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                n_fail++;
                $display("FAIL %s_word%0d: got %h last=%b want %h last=%b", name, i, got_q[i],
                         got_last_q[i], exp_q[i], (i == exp_q.size() - 1));
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({bus.out_valid, bus.out_last, bus.busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got v/l/b=%b%b%b want 000", bus.out_valid, bus.out_last,
                     bus.busy);
        end
        n_tests++;
        if (bus.out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", bus.out_data);
        end
        n_tests++;
        if (bus.out_bytes !== 16'h0 || bus.drop_cnt !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_counts: got bytes=%0d drop=%0d want 0 0", bus.out_bytes,
                     bus.drop_cnt);
        end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_frame();
        tx_q  = '{32'h11223344, 32'h55667788, 32'h99AABB00};
        exp_q = tx_q;
        send_frame(16'd11, 1'b0);
        collect(20);
        check_words("frame");
        n_tests++;
        if (first_valid !== 2) begin
            n_fail++;
            $display("FAIL frame_latency: got %0d cycles want 2", first_valid);
        end
        n_tests++;
        if (bus.out_bytes !== 16'd11) begin
            n_fail++;
            $display("FAIL frame_bytes: got %0d want 11", bus.out_bytes);
        end
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_end: got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_backpressure();
        fill_seq(4, 32'hA000_0000);
        exp_q     = tx_q;
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        send_frame(16'd16, 1'b0);
        collect(40);
        ready_pat = '{1'b1, 1'b1, 1'b1, 1'b1};
        check_words("bp");
        n_tests++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d changes while stalled want 0", unstable);
        end
    endtask

    task automatic test_overflow();
        int seen = 0;
        fill_seq(513, 32'hB000_0000);
        send_frame(16'd2052, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid || bus.busy) seen++;
            tick();
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL ovf_no_output: got %0d active cycles want 0", seen);
        end
        n_tests++;
        if (bus.drop_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL ovf_drop: got %0d want 1", bus.drop_cnt);
        end
        tx_q  = '{32'hCAFE0001, 32'hCAFE0002};
        exp_q = tx_q;
        send_frame(16'd8, 1'b0);
        collect(20);
        check_words("ovf_next");
    endtask

    task automatic test_collision();
        fill_seq(100, 32'h1000_0000);
        exp_q = tx_q;
        send_frame(16'd400, 1'b0);
        fork
            collect(300);
            begin
                repeat (10) tick();
                fill_seq(4, 32'hDEAD_0000);
                send_frame(16'd16, 1'b0);
            end
        join
        check_words("coll");
        n_tests++;
        if (bus.drop_cnt !== 8'd2 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_end: got drop=%0d busy=%b want 2 0", bus.drop_cnt, bus.busy);
        end
    endtask

    task automatic test_flush();
        fill_seq(3, 32'h2000_0000);
        exp_q = tx_q;
        send_frame(16'd12, 1'b0);
        fork
            collect(30);
            begin
                repeat (2) tick();
                bus.in_valid = 1'b1;
                bus.in_data  = 32'h5555_AAAA;
                tick();
                bus.in_valid = 1'b0;
            end
        join
        check_words("flush");
        n_tests++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.drop_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL flush_hold: got busy=%b valid=%b drop=%0d want 1 0 2", bus.busy,
                     bus.out_valid, bus.drop_cnt);
        end
        repeat (3) tick();
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.drop_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL flush_end: got busy=%b drop=%0d want 0 3", bus.busy, bus.drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int xfers = 0;
        fill_seq(8, 32'hC000_0000);
        send_frame(16'd32, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && xfers < 5; i++) begin
            if (bus.out_valid) xfers++;
            tick();
        end
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hC000_0005) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got valid=%b data=%h want 1 c0000005", bus.out_valid,
                     bus.out_data);
        end
        clr = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_now: got v/l/b=%b%b%b want 000", bus.out_valid, bus.out_last,
                     bus.busy);
        end
        n_tests++;
        if (bus.drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_mid_drop: got %0d want 0", bus.drop_cnt);
        end
        #2;
        clr = 1'b0;
        tick();
        tx_q  = '{32'hD000_0001, 32'hD000_0002};
        exp_q = tx_q;
        send_frame(16'd8, 1'b0);
        collect(20);
        check_words("rst_next");
    endtask

    task automatic test_edge();
        int seen = 0;
        tx_q  = '{32'hE1E2E3E4};
        exp_q = tx_q;
        send_frame(16'd4, 1'b1);
        collect(20);
        check_words("edge1");
        n_tests++;
        if (first_valid !== 2 || bus.out_bytes !== 16'd4) begin
            n_fail++;
            $display("FAIL edge1_timing: got lat=%0d bytes=%0d want 2 4", first_valid,
                     bus.out_bytes);
        end
        bus.frame_done = 1'b1;
        bus.in_bytes   = 16'd0;
        tick();
        bus.frame_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid || bus.busy) seen++;
            tick();
        end
        n_tests++;
        if (seen !== 0 || bus.drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL edge_empty: got active=%0d drop=%0d want 0 0", seen, bus.drop_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int f = 0; f < 3; f++) begin
            fill_seq(100, 32'h3000_0000);
            send_frame(16'd400, 1'b0);
            bus.out_ready  = 1'b1;
            bus.frame_done = 1'b1;
            repeat (95) tick();
            bus.frame_done = 1'b0;
            for (int i = 0; i < 20 && bus.busy; i++) tick();
            if (f == 0) begin
                n_tests++;
                if (bus.drop_cnt !== 8'd95) begin
                    n_fail++;
                    $display("FAIL sat_first: got %0d want 95", bus.drop_cnt);
                end
            end
        end
        n_tests++;
        if (bus.drop_cnt !== 8'd255 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_final: got drop=%0d busy=%b want 255 0", bus.drop_cnt, bus.busy);
        end
    endtask

    initial begin
        clr            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.frame_done = 1'b0;
        bus.in_bytes   = '0;
        bus.out_ready  = 1'b1;
        ready_pat      = '{1'b1, 1'b1, 1'b1, 1'b1};
        test_reset();
        test_frame();
        test_backpressure();
        test_overflow();
        test_collision();
        test_flush();
        test_reset_mid();
        test_edge();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish within 1 ms want finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/g_udp_rxbuf.md
G_UDP_RXBUF -- requirements
Module: g_udp_rxbuf

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, word-address width (buffer depth 2^ADDR_W = 512 words).
REQ-002 SHALL have parameter DATA_W, default 32, payload word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, one packed payload word is present on in_data.
REQ-006 SHALL have port in_data, input, DATA_W, payload word, first byte in bits [31:24].
REQ-007 SHALL have port frame_done, input, 1, single-cycle pulse marking the end of a received UDP frame.
REQ-008 SHALL have port in_bytes, input, 16, payload byte count (UDP length minus 8), sampled on frame_done.
REQ-009 SHALL have port out_data, output, DATA_W, buffered payload word.
REQ-010 SHALL have port out_valid, output, 1, out_data is valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-012 SHALL have port out_last, output, 1, the current out_data is the final word of the frame.
REQ-013 SHALL have port out_bytes, output, 16, latched payload byte count of the frame being drained.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE and FILL.
REQ-015 SHALL have port drop_cnt, output, 8, saturating count of discarded frames.

Function
REQ-016 SHALL implement the states IDLE, FILL, PRIME, DRAIN and FLUSH.
REQ-017 IDLE: in_valid SHALL write in_data at write pointer 0, set the pointer to 1 and go to FILL.
REQ-018 FILL: each in_valid SHALL write at the write pointer and increment it.
REQ-019 SHALL write the in_valid word and then end the frame when in_valid and frame_done coincide.
REQ-020 On frame_done with word count 0 (in IDLE), SHALL stay in IDLE, produce no output and leave drop_cnt unchanged.
REQ-021 On frame_done with word count from 1 to 512 and no overflow, SHALL latch the word count and in_bytes (to out_bytes), then go to PRIME.
REQ-022 Overflow: an in_valid while the count is 512 SHALL be discarded and set an overflow flag.
REQ-023 At frame_done with the overflow flag set, SHALL increment drop_cnt, clear the flag and pointer, and go to IDLE.
REQ-024 PRIME: SHALL issue a RAM read of address 0 and go to DRAIN next cycle; the RAM has 1-cycle read latency.
REQ-025 First out_valid SHALL assert exactly 2 cycles after the frame_done cycle.
REQ-026 DRAIN: SHALL transfer a word in a cycle where out_valid and out_ready are both high.
REQ-027 DRAIN: out_data and out_last SHALL hold stable while out_valid and not out_ready.
REQ-028 DRAIN: SHALL sustain one word per cycle when out_ready is held high (read-ahead / skid register).
REQ-029 out_last SHALL be high only on word index count-1.
REQ-030 On the transfer with out_last high, SHALL deassert out_valid next cycle and go to IDLE.
REQ-031 In PRIME or DRAIN, in_valid words SHALL be ignored; a frame_done arriving in PRIME or DRAIN SHALL increment drop_cnt.
REQ-032 in_valid in PRIME/DRAIN SHALL set a drop-pending flag; if the drain ends before that frame's frame_done, SHALL go to FLUSH.
REQ-033 FLUSH: SHALL discard in_valid words; on frame_done SHALL increment drop_cnt and go to IDLE.
REQ-034 drop_cnt SHALL saturate at 255.

Reset
REQ-035 clr high SHALL, asynchronously, force state IDLE and clear all of these to 0: out_valid, out_last, out_data, out_bytes, busy, drop_cnt, pointers, flags.
REQ-036 Reset mid-DRAIN SHALL abandon the frame without out_last and without incrementing drop_cnt; RAM contents are not cleared.

Structure
REQ-037 A shared package SHALL hold the state encoding, DEPTH=512, ADDR_W=9 and DATA_W=32.
REQ-038 Storage SHALL be one sub-module, g_rxbuf_ram: simple dual-port 512x32, registered read, no reset.

Verification
REQ-039 Frame test: 3 words 0x11223344, 0x55667788, 0x99AABB00, in_bytes=11, out_ready=1 -> same words on consecutive cycles; out_last on the 3rd; out_bytes=11; first out_valid 2 cycles after frame_done.
REQ-040 Backpressure test: out_ready toggles 1,0,0,1 on a 4-word frame -> every word held stable while stalled; no duplicate or lost words.
REQ-041 Overflow test: 513 words then frame_done -> no out_valid; drop_cnt=1; next 2-word frame is delivered correctly.
REQ-042 Collision test: a 4-word frame arrives during drain of a 100-word frame -> the 100 words are intact; drop_cnt increments by 1; state returns to IDLE.
REQ-043 Reset test: clr pulsed at drain word 5 -> out_valid=0 immediately; drop_cnt=0; next frame is delivered correctly.
REQ-044 Edge test: in_valid and frame_done in the same cycle for a 1-word frame -> one word out with out_last=1; an empty frame_done in IDLE -> no output.
